// File: rtl/div_seq_if.sv
// Operand/result bundle between the MIPS control/datapath and the sequential divider.
interface div_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        done;
  logic        div_zero;
  logic        busy;

  modport master (
    output start, a, b,
    input  lo, hi, done, div_zero, busy
  );

  modport slave (
    input  start, a, b,
    output lo, hi, done, div_zero, busy
  );
endinterface

// File: rtl/div_seq.sv
// Sequential 32-bit signed divider, restoring algorithm, one quotient bit per cycle.
// Quotient truncates toward zero, remainder follows the dividend sign (MIPS DIV).
//
// state | meaning
// IDLE  | waiting for start; operands sampled here
// CALC  | 32 shift/subtract iterations
// FIX   | apply signs, write lo/hi, raise done
// DONE  | drop done/div_zero, return to IDLE
module div_seq (
  input  logic     clock,
  input  logic     reset,
  div_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [32:0] rem;
  logic [4:0]  count;
  logic        sign_q;
  logic        sign_r;

  logic [31:0] lo_r;
  logic [31:0] hi_r;
  logic        done_r;
  logic        div_zero_r;

  logic        load;
  logic        load_zero;
  logic        step;
  logic        fix;
  logic        busy_c;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [33:0] rem_shift;
  logic [33:0] trial;

  // Magnitudes as unsigned 32-bit values, so |-2^31| is 0x80000000.
  assign a_mag = bus.a[31] ? (32'd0 - bus.a) : bus.a;
  assign b_mag = bus.b[31] ? (32'd0 - bus.b) : bus.b;

  // The dividend register doubles as the quotient: its MSB shifts into the
  // remainder and the new quotient bit enters at the LSB.
  assign rem_shift = {rem, dividend[31]};
  assign trial     = rem_shift - {2'b00, divisor};

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state selection.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start) state_next = (bus.b == 32'd0) ? DONE : CALC;
      CALC: if (count == 5'd31) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-state control strobes.
  always_comb begin
    load      = 1'b0;
    load_zero = 1'b0;
    step      = 1'b0;
    fix       = 1'b0;
    busy_c    = (state != IDLE);
    case (state)
      IDLE: begin
        load      = bus.start && (bus.b != 32'd0);
        load_zero = bus.start && (bus.b == 32'd0);
      end
      CALC:    step = 1'b1;
      FIX:     fix  = 1'b1;
      default: ;
    endcase
  end

  // Operand capture and the restoring iteration.
  always_ff @(posedge clock) begin
    if (reset) begin
      dividend <= 32'd0;
      divisor  <= 32'd0;
      rem      <= 33'd0;
      count    <= 5'd0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
    end else if (load) begin
      dividend <= a_mag;
      divisor  <= b_mag;
      rem      <= 33'd0;
      count    <= 5'd0;
      sign_q   <= bus.a[31] ^ bus.b[31];
      sign_r   <= bus.a[31];
    end else if (step) begin
      rem      <= trial[33] ? rem_shift[32:0] : trial[32:0];
      dividend <= {dividend[30:0], ~trial[33]};
      count    <= count + 5'd1;
    end
  end

  // Registered results and status pulses; lo/hi only change on FIX.
  always_ff @(posedge clock) begin
    if (reset) begin
      lo_r       <= 32'd0;
      hi_r       <= 32'd0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      done_r     <= load_zero | fix;
      div_zero_r <= load_zero;
      if (fix) begin
        lo_r <= sign_q ? (32'd0 - dividend) : dividend;
        hi_r <= sign_r ? (32'd0 - rem[31:0]) : rem[31:0];
      end
    end
  end

  assign bus.lo       = lo_r;
  assign bus.hi       = hi_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;
  assign bus.busy     = busy_c;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: signed results, latency, divide-by-zero, ignored start, reset abort.
module tb_div_seq;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  div_seq_if bus ();

  div_seq dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Caller is between edges; start is seen by the next rising edge (edge k).
  task automatic start_div(input logic [31:0] a, input logic [31:0] b);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
  endtask

  // lat = index of the first falling edge with done high (0 = right after edge k).
  task automatic wait_done(output int lat, output bit busy_ok);
    lat     = -1;
    busy_ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int lat;
    bit busy_ok;
    start_div(a, b);
    wait_done(lat, busy_ok);
    check({tag, "_lat"}, lat, 33);
    check({tag, "_busy"}, {31'd0, busy_ok}, 1);
    check({tag, "_lo"}, bus.lo, exp_lo);
    check({tag, "_hi"}, bus.hi, exp_hi);
    check({tag, "_dz"}, {31'd0, bus.div_zero}, 0);
    @(negedge clock);
    check({tag, "_done_clr"}, {31'd0, bus.done}, 0);
    check({tag, "_idle"}, {31'd0, bus.busy}, 0);
  endtask

  initial begin
    int lat;
    bit busy_ok;
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_lo", bus.lo, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_done", {31'd0, bus.done}, 0);
    check("rst_dz", {31'd0, bus.div_zero}, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);

    // Back-to-back runs also exercise acceptance at the earliest edge k+35.
    run_div("p100_7", 32'd100, 32'd7, 32'd14, 32'd2);

    start_div(32'd5, 32'd0);
    wait_done(lat, busy_ok);
    check("dz_lat", lat, 0);
    check("dz_flag", {31'd0, bus.div_zero}, 1);
    check("dz_lo_hold", bus.lo, 32'd14);
    check("dz_hi_hold", bus.hi, 32'd2);
    @(negedge clock);
    check("dz_done_clr", {31'd0, bus.done}, 0);
    check("dz_flag_clr", {31'd0, bus.div_zero}, 0);
    check("dz_idle", {31'd0, bus.busy}, 0);

    run_div("m7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("p7_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run_div("m7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
    run_div("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_div("m1_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0);

    // Second start at edge 5 must not disturb the 100/7 in flight.
    start_div(32'd100, 32'd7);
    repeat (4) @(posedge clock);
    #1;
    start_div(32'd9, 32'd3);
    bus.a = 32'd1;
    bus.b = 32'd1;
    wait_done(lat, busy_ok);
    check("ign_lat", lat, 28);
    check("ign_lo", bus.lo, 32'd14);
    check("ign_hi", bus.hi, 32'd2);
    @(negedge clock);

    // Reset at edge 10 aborts; new 9/3 at edge 12 finishes after edge 45.
    start_div(32'd100, 32'd7);
    repeat (9) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("abort_lo", bus.lo, 0);
    check("abort_hi", bus.hi, 0);
    check("abort_busy", {31'd0, bus.busy}, 0);
    check("abort_done", {31'd0, bus.done}, 0);
    @(posedge clock);
    #1;
    start_div(32'd9, 32'd3);
    wait_done(lat, busy_ok);
    check("restart_lat", lat, 33);
    check("restart_lo", bus.lo, 32'd3);
    check("restart_hi", bus.hi, 32'd0);
    @(negedge clock);

    // Reset and start at the same edge: start is dropped.
    bus.a     = 32'd9;
    bus.b     = 32'd3;
    bus.start = 1'b1;
    reset     = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    reset     = 1'b0;
    @(negedge clock);
    check("rst_start_busy", {31'd0, bus.busy}, 0);
    check("rst_start_lo", bus.lo, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
